ct_decrypt_seq: RTL



---
 rtl/ct_decrypt_seq_pkg.sv | 37 +++
 rtl/ct_decrypt_seq_slot_decode.sv | 27 ++
 rtl/ct_decrypt_seq.sv | 72 +++++++
 3 files changed

// File: rtl/ct_decrypt_seq_pkg.sv
// Shared types and constants for the sequential ciphertext decryptor.
// Slot datapath helpers live here so a parallel decryptor can reuse them.
package ct_decrypt_seq_pkg;

    localparam int N_SLOTS = 4;
    localparam int W       = 16;
    localparam int Q       = 4096;
    localparam int DELTA   = 256;
    localparam int T       = Q / DELTA;
    localparam int PW      = $clog2(T);
    localparam int DSH     = $clog2(DELTA);
    localparam int KW      = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

    typedef logic [W-1:0]               word_t;
    typedef word_t [N_SLOTS-1:0]        vec_t;
    typedef logic [PW-1:0]              pt_word_t;
    typedef pt_word_t [N_SLOTS-1:0]     pt_t;

    typedef struct packed {
        vec_t a;
        vec_t b;
    } ct_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Constant-modulus reduction of a full-width product into [0,Q).
    function automatic word_t mod_q(input logic [2*W-1:0] v);
        logic [2*W-1:0] r;
        r = v % (2*W)'(Q);
        return r[W-1:0];
    endfunction

endpackage

// File: rtl/ct_decrypt_seq_slot_decode.sv
// Combinational decode of one slot: m = round(((b - a*s) mod Q) / DELTA) mod T.
module slot_decode
    import ct_decrypt_seq_pkg::*;
(
    input  word_t    a,
    input  word_t    b,
    input  word_t    s,
    output pt_word_t m
);

    logic [2*W-1:0] prod;
    word_t          p;
    logic [W:0]     x;
    logic [W:0]     y;

    assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, s};
    assign p    = mod_q(prod);

    // W+1 bits so that b + Q cannot overflow when Q == 2^W.
    assign x = (b >= p) ? ({1'b0, b} - {1'b0, p})
                        : ({1'b0, b} + (W+1)'(Q) - {1'b0, p});
    assign y = x + (W+1)'(DELTA / 2);

    // T is a power of two, so truncation implements the final mod T wrap.
    assign m = pt_word_t'(y >> DSH);

endmodule

// File: rtl/ct_decrypt_seq.sv
// Sequential decryptor: captures one ciphertext and key, decodes one slot per
// clock through a single shared slot datapath, then holds the plaintext.
module ct_decrypt_seq
    import ct_decrypt_seq_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid,
    output logic   in_ready,
    input  ct_t    in_ct,
    input  vec_t   in_sk,
    output logic   out_valid,
    input  logic   out_ready,
    output pt_t    out_pt,
    output state_t dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; valid never waits on ready, and ready comes only from state.
    state_t          state;
    ct_t             ct_q;
    vec_t            sk_q;
    logic [KW-1:0]   k;
    pt_word_t        slot_m;

    slot_decode u_slot (
        .a (ct_q.a[k]),
        .b (ct_q.b[k]),
        .s (sk_q[k]),
        .m (slot_m)
    );

    assign in_ready  = (state == S_IDLE) && !rst;
    assign out_valid = (state == S_DONE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            k      <= '0;
            out_pt <= '0;
            ct_q   <= '0;
            sk_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        ct_q  <= in_ct;
                        sk_q  <= in_sk;
                        k     <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    out_pt[k] <= slot_m;
                    if (k == KW'(N_SLOTS - 1)) begin
                        state <= S_DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
